// File: rtl/bcd_to_bin.sv
// rtl/bcd_to_bin.sv - sign-magnitude 3-digit BCD to N-bit two's-complement converter
// Reverse double-dabble: ten right shifts with a -3 correction on each BCD digit field >= 8.
module bcd_to_bin #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         sign,
   input  logic [3:0]   hundreds,
   input  logic [3:0]   tens,
   input  logic [3:0]   ones,
   output logic [N-1:0] binary,
   output logic         error,
   output logic         busy,
   output logic         data_ready
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      CHECK = 2'd2,
      READY = 2'd3
   } state_t;

   localparam logic [16:0] MAX_NEG = 17'd1 << (N - 1);
   localparam logic [16:0] MAX_POS = MAX_NEG - 17'd1;

   state_t       state_q, state_d;
   logic [21:0]  sr_q, sr_d;
   logic [3:0]   cnt_q, cnt_d;
   logic         sign_q, sign_d;
   logic         bad_q, bad_d;
   logic [N-1:0] bin_q, bin_d;
   logic         err_q, err_d;

   logic [21:0]  shifted;
   logic [16:0]  mag_ext;
   logic [16:0]  neg_ext;
   logic         ovf;
   logic         load;

   function automatic logic [3:0] adj(input logic [3:0] d);
      return (d >= 4'd8) ? (d - 4'd3) : d;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
         sign_q  <= 1'b0;
         bad_q   <= 1'b0;
         bin_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         sign_q  <= sign_d;
         bad_q   <= bad_d;
         bin_q   <= bin_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      shifted = {1'b0, sr_q[21:1]};
      mag_ext = {7'd0, sr_q[9:0]};
      neg_ext = 17'd0 - mag_ext;
      ovf     = sign_q ? (mag_ext > MAX_NEG) : (mag_ext > MAX_POS);
      load    = start && ((state_q == IDLE) || (state_q == READY));
   end

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      sign_d  = sign_q;
      bad_d   = bad_q;
      bin_d   = bin_q;
      err_d   = err_q;

      case (state_q)
         IDLE, READY: begin
            if (load) begin
               sr_d    = {hundreds, tens, ones, 10'd0};
               cnt_d   = 4'd10;
               sign_d  = sign;
               bad_d   = (hundreds > 4'd9) || (tens > 4'd9) || (ones > 4'd9);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            sr_d  = {adj(shifted[21:18]), adj(shifted[17:14]), adj(shifted[13:10]),
                     shifted[9:0]};
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = CHECK;
            end
         end
         CHECK: begin
            // Negation is done on the zero-extended magnitude so -0 stays 0.
            if (bad_q || ovf) begin
               bin_d = '0;
               err_d = 1'b1;
            end else begin
               bin_d = sign_q ? neg_ext[N-1:0] : mag_ext[N-1:0];
               err_d = 1'b0;
            end
            state_d = READY;
         end
         default: state_d = IDLE;
      endcase
   end

   assign binary     = bin_q;
   assign error      = err_q;
   assign busy       = (state_q == SHIFT) || (state_q == CHECK);
   assign data_ready = (state_q == READY);

endmodule

// File: tb/tb_bcd_to_bin.sv
// tb/tb_bcd_to_bin.sv - randomized bench for bcd_to_bin with an arithmetic reference model
// Two instances (N=8 and N=12) share one stimulus; the model tracks edges since an accepted start.
module tb_bcd_to_bin;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        sign = 1'b0;
   logic [3:0]  hundreds = '0;
   logic [3:0]  tens = '0;
   logic [3:0]  ones = '0;

   logic [7:0]  bin8;
   logic        err8, busy8, dr8;
   logic [11:0] bin12;
   logic        err12, busy12, dr12;

   int n_total = 0;
   int n_bad   = 0;
   bit mon_en  = 1'b0;

   always #5 clk = ~clk;

   bcd_to_bin #(.N(8)) dut8 (
      .clk(clk), .rst(rst), .start(start), .sign(sign),
      .hundreds(hundreds), .tens(tens), .ones(ones),
      .binary(bin8), .error(err8), .busy(busy8), .data_ready(dr8)
   );

   bcd_to_bin #(.N(12)) dut12 (
      .clk(clk), .rst(rst), .start(start), .sign(sign),
      .hundreds(hundreds), .tens(tens), .ones(ones),
      .binary(bin12), .error(err12), .busy(busy12), .data_ready(dr12)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Result from plain arithmetic on the decimal value.
   function automatic void model_result(input int nb, input bit s, input int h, input int t,
                                        input int o, output logic [15:0] b, output logic e);
      int  m;
      int  lim;
      int  v;
      bit  bad;
      bit  ovf;
      m   = 100 * h + 10 * t + o;
      bad = (h > 9) || (t > 9) || (o > 9);
      lim = 1 << (nb - 1);
      ovf = s ? (m > lim) : (m > lim - 1);
      if (bad || ovf) begin
         b = 16'd0;
         e = 1'b1;
      end else begin
         v = s ? -m : m;
         b = 16'(v & ((1 << nb) - 1));
         e = 1'b0;
      end
   endfunction

   int          age = -1;
   bit          ready_m = 1'b0;
   bit          l_sign;
   int          l_h, l_t, l_o;
   logic [15:0] exp_bin8 = '0, exp_bin12 = '0;
   logic        exp_err8 = 1'b0, exp_err12 = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         age = -1;
         ready_m = 1'b0;
         exp_bin8 = '0;
         exp_bin12 = '0;
         exp_err8 = 1'b0;
         exp_err12 = 1'b0;
      end else if (age >= 0) begin
         age++;
         if (age == 11) begin
            model_result(8, l_sign, l_h, l_t, l_o, exp_bin8, exp_err8);
            model_result(12, l_sign, l_h, l_t, l_o, exp_bin12, exp_err12);
            age = -1;
            ready_m = 1'b1;
         end
      end else if (start) begin
         l_sign = sign;
         l_h = int'(hundreds);
         l_t = int'(tens);
         l_o = int'(ones);
         age = 0;
         ready_m = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         chk("busy8",  32'(busy8),  32'(age >= 0));
         chk("dr8",    32'(dr8),    32'(ready_m));
         chk("bin8",   32'(bin8),   32'(exp_bin8[7:0]));
         chk("err8",   32'(err8),   32'(exp_err8));
         chk("busy12", 32'(busy12), 32'(age >= 0));
         chk("dr12",   32'(dr12),   32'(ready_m));
         chk("bin12",  32'(bin12),  32'(exp_bin12[11:0]));
         chk("err12",  32'(err12),  32'(exp_err12));
      end
   end

   task automatic run_conv(input bit s, input int h, input int t, input int o, output int lat);
      @(negedge clk);
      sign = s;
      hundreds = 4'(h);
      tens = 4'(t);
      ones = 4'(o);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      while (!dr8 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk("latency", 32'(lat), 32'd12);
   endtask

   int lat;
   int v;

   initial begin
      repeat (2) @(negedge clk);
      mon_en = 1'b1;
      chk("rst_bin8", 32'(bin8), 32'd0);
      chk("rst_flags", {28'd0, err8, busy8, dr8, err12}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      run_conv(1'b0, 1, 2, 7, lat);
      chk("lit127", 32'(bin8), 32'h7F);
      chk("lit127_err", 32'(err8), 32'd0);
      run_conv(1'b1, 1, 2, 8, lat);
      chk("litm128", 32'(bin8), 32'h80);
      chk("litm128_err", 32'(err8), 32'd0);
      run_conv(1'b0, 1, 2, 8, lat);
      chk("lit128_ovf", {23'd0, err8, bin8}, 32'h100);
      run_conv(1'b1, 9, 9, 9, lat);
      chk("litm999_err8", 32'(err8), 32'd1);
      chk("litm999_n12", 32'(bin12), 32'hC19);
      run_conv(1'b0, 0, 0, 10, lat);
      chk("lit_baddigit", {23'd0, err8, bin8}, 32'h100);
      run_conv(1'b1, 0, 0, 0, lat);
      chk("lit_negzero", {23'd0, err8, bin8}, 32'h000);

      // Start held high in READY: data_ready drops for one conversion.
      @(negedge clk);
      sign = 1'b0; hundreds = 4'd0; tens = 4'd4; ones = 4'd2;
      start = 1'b1;
      @(negedge clk);
      chk("held_dr_drop", 32'(dr8), 32'd0);
      lat = 1;
      while (!dr8 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      chk("held_latency", 32'(lat), 32'd12);
      chk("lit042_n12", 32'(bin12), 32'h02A);

      // Start pulse during SHIFT is ignored.
      @(negedge clk);
      sign = 1'b0; hundreds = 4'd0; tens = 4'd9; ones = 4'd9;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 5;
      while (!dr8 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk("pulse_latency", 32'(lat), 32'd12);
      chk("lit99", 32'(bin8), 32'd99);

      // Reset at SHIFT step 5 aborts the conversion.
      @(negedge clk);
      sign = 1'b1; hundreds = 4'd0; tens = 4'd5; ones = 4'd0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_outs", {20'd0, bin8, err8, busy8, dr8, 1'b0}, 32'd0);
      repeat (15) @(negedge clk);
      chk("abort_no_dr", 32'(dr8), 32'd0);

      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 3))
            0: v = $urandom_range(120, 135);
            1: v = $urandom_range(0, 999);
            2: v = $urandom_range(2040, 2050) % 1000;
            default: v = -1;
         endcase
         if (v >= 0)
            run_conv(1'($urandom_range(0, 1)), v / 100, (v / 10) % 10, v % 10, lat);
         else
            run_conv(1'($urandom_range(0, 1)), $urandom_range(0, 15),
                     $urandom_range(0, 15), $urandom_range(0, 15), lat);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
